// File: rtl/eif_pkg.sv
// -----------------------------------------------------------------------------
// eif_pkg
// Shared definitions for the spike rate decoder.
//   isi_state_t  : ISI tracking state (IDLE / ARMED / TRACK)
//   WIN_LOG2_DEF : default log2 of the measurement window length in cycles
//   CNT_W_DEF    : default width of the rate / ISI result fields
// -----------------------------------------------------------------------------
package eif_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // no spike event since reset
      ARMED = 2'd1,   // one event seen, ISI timer running
      TRACK = 2'd2    // two or more events seen, isi is meaningful
   } isi_state_t;

   localparam int WIN_LOG2_DEF = 8;
   localparam int CNT_W_DEF    = 8;

endpackage

// File: rtl/spike_rate_decoder_isi_timer.sv
// -----------------------------------------------------------------------------
// isi_timer
// Saturating cycle counter that measures the interval between spike events.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset, clears count to 0
//   en      in   advance / restart allowed only when high (otherwise frozen)
//   restart in   load 1 on this edge (the event cycle itself is interval 0)
//   count   out  CNT_W-bit cycle count, sticks at all-ones
// -----------------------------------------------------------------------------
module isi_timer
   import eif_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             restart,
   output logic [CNT_W-1:0] count
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (en) begin
         if (restart) count <= CNT_W'(1);
         else         count <= sat_inc(count);
      end
   end

endmodule

// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
// Counts rising edges of a neuron spike line over fixed windows of
// 2^WIN_LOG2 cycles and publishes the count (and optionally the most recent
// inter-spike interval) through a valid/ready result port.
//
// Optional feature macro: ISI_MEASURE_EN
//   defined   : ISI timer, tracking state machine and isi register are built
//   undefined : isi is tied to 0, rate path identical
//
// Parameters:
//   WIN_LOG2  window length = 2^WIN_LOG2 cycles (4..16)
//   CNT_W     width of rate / isi
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   ena       in   measurement enable; 0 freezes all counters and state
//   spike_in  in   spike level from the neuron
//   rate      out  event count of the last completed window
//   isi       out  last inter-spike interval in cycles (captured at each wrap)
//   out_valid out  rate/isi hold an unconsumed result
//   out_ready in   consumer accepts when out_valid && out_ready
//   overrun   out  sticky: a result was overwritten before acceptance
// -----------------------------------------------------------------------------
module spike_rate_decoder
   import eif_pkg::*;
#(
   parameter int WIN_LOG2 = WIN_LOG2_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             spike_in,
   output logic [CNT_W-1:0] rate,
   output logic [CNT_W-1:0] isi,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overrun
);

   localparam logic [WIN_LOG2-1:0] WIN_LAST = {WIN_LOG2{1'b1}};

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   logic                spike_p0;   // one-cycle registered copy of spike_in
   logic                evt;
   logic                wrap;
   logic [WIN_LOG2-1:0] win_cnt;
   logic [CNT_W-1:0]    evt_cnt;
   logic [CNT_W-1:0]    evt_total;

   // An event in the wrap cycle belongs to the closing window, so the value
   // loaded into rate already includes it.
   assign evt       = ena & spike_in & ~spike_p0;
   assign wrap      = ena & (win_cnt == WIN_LAST);
   assign evt_total = evt ? sat_inc(evt_cnt) : evt_cnt;

   // ---- stage p0: edge register, window/event counters, result handshake ----
   always_ff @(posedge clk) begin
      if (rst) begin
         spike_p0  <= 1'b0;
         win_cnt   <= '0;
         evt_cnt   <= '0;
         rate      <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         spike_p0 <= spike_in;
         if (ena) begin
            win_cnt <= win_cnt + 1'b1;
            evt_cnt <= wrap ? '0 : evt_total;
         end
         if (wrap) begin
            rate      <= evt_total;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) overrun <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef ISI_MEASURE_EN
   isi_state_t       state, state_nxt;
   logic [CNT_W-1:0] isi_cnt;
   logic [CNT_W-1:0] isi_last, isi_nxt;

   isi_timer #(.CNT_W(CNT_W)) u_isi_timer (
      .clk     (clk),
      .rst     (rst),
      .en      (ena),
      .restart (evt),
      .count   (isi_cnt)
   );

   // isi_last follows every event; the isi output is only refreshed on a wrap
   // so that rate and isi change together and stay stable while out_valid=1.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         isi_last <= '0;
         isi      <= '0;
      end else begin
         state    <= state_nxt;
         isi_last <= isi_nxt;
         if (wrap) isi <= isi_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      isi_nxt   = isi_last;
      if (evt) begin
         case (state)
            IDLE:    state_nxt = ARMED;
            ARMED: begin
               state_nxt = TRACK;
               isi_nxt   = isi_cnt;
            end
            TRACK:   isi_nxt   = isi_cnt;
            default: state_nxt = IDLE;
         endcase
      end
   end
`else
   assign isi = '0;
`endif

endmodule
